iterative_muldiv: RTL and testbench
===================================

ITERATIVE_MULDIV -- requirements
Module: iterative_muldiv

Interface
REQ-001 Parameter: WIDTH, 32, operand/result width in bits; legal values 8..64, even.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request; sampled only in IDLE.
REQ-005 Port: func  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 Port: opA  input  WIDTH  rs1 operand; dividend for divide ops.
REQ-007 Port: opB  input  WIDTH  rs2 operand; divisor for divide ops.
REQ-008 Port: busy  output  1  high in CALC and DONE; low only in IDLE.
REQ-009 Port: done  output  1  one-cycle pulse; result valid.
REQ-010 Port: result  output  WIDTH  selected result; held from done until the next accepted start.

Function
REQ-011 The FSM SHALL have three states: IDLE, CALC, DONE.
REQ-012 IDLE and start=1 at an edge SHALL latch func, opA and opB, load the iteration counter with WIDTH, and go to CALC.
REQ-013 CALC SHALL perform one radix-2 step per cycle: shift-add for multiply, restoring subtract-shift for divide, on operand magnitudes.
REQ-014 CALC SHALL decrement the counter each cycle and enter DONE on the cycle the counter reaches 0.
REQ-015 DONE SHALL assert done for exactly one cycle, drive the final result, then return to IDLE.
REQ-016 Latency: done SHALL be high in the (WIDTH+1)th cycle after the start edge (33 cycles at WIDTH=32). Back-to-back starts SHALL be accepted in IDLE only.
REQ-017 start, func, opA and opB SHALL be ignored while busy=1; latched operands SHALL be unaffected by input changes.
REQ-018 Multiply SHALL form the full 2*WIDTH product.
  - MUL returns the low half.
  - MULH returns the high half, signed x signed.
  - MULHSU returns the high half, signed opA x unsigned opB.
  - MULHU returns the high half, unsigned x unsigned.
REQ-019 Signed ops SHALL take magnitudes at latch time and apply the sign in DONE.
  - Product sign = XOR of the operand signs.
  - Quotient sign = XOR of the operand signs.
  - Remainder sign = dividend sign.
REQ-020 Divide by zero SHALL return a quotient of all ones (DIV and DIVU) and a remainder equal to opA (REM and REMU).
REQ-021 Signed overflow (opA = most-negative value, opB = -1) SHALL return quotient = opA and remainder = 0.
REQ-022 result SHALL update only in DONE.

Reset
REQ-023 rst=1 at an edge SHALL force IDLE and clear the counter, busy, done and result to 0, including mid-CALC and in DONE; the aborted operation produces no done.
REQ-024 rst SHALL take priority over start at the same edge.

Configuration
REQ-025 Macro MULDIV_EARLY_OUT_EN: when defined, a divide with opB=0 SHALL skip CALC and go IDLE->DONE, with done in the 1st cycle after the start edge and REQ-020 values.
REQ-026 Without MULDIV_EARLY_OUT_EN, all ops SHALL take the REQ-016 latency. Result values SHALL be identical either way.

Structure
REQ-027 Package muldiv_pkg SHALL hold the func encoding constants, the FSM state typedef and the default WIDTH constant.
REQ-028 Sub-module muldiv_step SHALL be combinational and implement one iteration.
  - Inputs: accumulator, partial operand, mode.
  - Outputs: next accumulator and next partial operand.
  - iterative_muldiv owns the FSM, counter, sign fix-up and result register.

Verification
REQ-029 WIDTH=32, MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; done exactly 33 cycles after the start edge; busy high 33 cycles.
REQ-030 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH of the same operands -> 0x00000000; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0; REM 0xFFFFFFF9 % 2 -> 0xFFFFFFFF.
REQ-032 DIVU 100 / 0 -> 0xFFFFFFFF; REMU 100 / 0 -> 100.
  - With MULDIV_EARLY_OUT_EN: done 1 cycle after start.
  - Without it: done 33 cycles after start.
REQ-033 A second start with new operands at cycle 5 of CALC is ignored and result matches the first op; rst at cycle 10 of CALC gives busy=0, done=0 and result=0 the next cycle, and no done follows.

Source files
------------

// File: rtl/muldiv_pkg.sv
//------------------------------------------------------------------------------
// Module   : muldiv_pkg
// Desc     : Shared constants and types for the iterative multiply/divide unit.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package muldiv_pkg;

  localparam int c_default_width = 32;

  localparam logic [2:0] c_func_mul    = 3'b000;
  localparam logic [2:0] c_func_mulh   = 3'b001;
  localparam logic [2:0] c_func_mulhsu = 3'b010;
  localparam logic [2:0] c_func_mulhu  = 3'b011;
  localparam logic [2:0] c_func_div    = 3'b100;
  localparam logic [2:0] c_func_divu   = 3'b101;
  localparam logic [2:0] c_func_rem    = 3'b110;
  localparam logic [2:0] c_func_remu   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic {
    STEP_MUL = 1'b0,
    STEP_DIV = 1'b1
  } step_mode_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_step.sv
//------------------------------------------------------------------------------
// Module   : muldiv_step
// Desc     : One radix-2 iteration: shift-add multiply or restoring divide.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module muldiv_step
  import muldiv_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  step_mode_e       i_mode,
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_part,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_part
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  always_comb begin
    w_sum   = {1'b0, i_acc} + (i_part[0] ? {1'b0, i_opnd} : '0);
    w_shift = {i_acc, i_part[WIDTH-1]};
    w_ge    = (w_shift >= {1'b0, i_opnd});
    // Remainder stays below the divisor, so the low WIDTH bits suffice.
    w_diff  = w_shift[WIDTH-1:0] - i_opnd;
    o_acc   = i_acc;
    o_part  = i_part;
    if (i_mode == STEP_MUL) begin
      o_acc  = w_sum[WIDTH:1];
      o_part = {w_sum[0], i_part[WIDTH-1:1]};
    end else if (w_ge) begin
      o_acc  = w_diff;
      o_part = {i_part[WIDTH-2:0], 1'b1};
    end else begin
      o_acc  = w_shift[WIDTH-1:0];
      o_part = {i_part[WIDTH-2:0], 1'b0};
    end
  end

endmodule

`default_nettype wire

// File: rtl/iterative_muldiv.sv
//------------------------------------------------------------------------------
// Module   : iterative_muldiv
// Desc     : RV32M-style iterative multiply/divide; MULDIV_EARLY_OUT_EN lets a
//            divide by zero skip the iteration phase.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module iterative_muldiv
  import muldiv_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       func,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam int c_cnt_w = $clog2(WIDTH + 1);

  state_e             r_state_q, w_state_d;
  logic [c_cnt_w-1:0] r_cnt_q, w_cnt_d;
  logic [2:0]         r_func_q, w_func_d;
  logic [WIDTH-1:0]   r_acc_q, w_acc_d;
  logic [WIDTH-1:0]   r_part_q, w_part_d;
  logic [WIDTH-1:0]   r_opnd_q, w_opnd_d;
  logic [WIDTH-1:0]   r_opa_q, w_opa_d;
  logic               r_neg_q, w_neg_d;
  logic               r_div0_q, w_div0_d;
  logic [WIDTH-1:0]   r_result_q, w_result_d;

  logic               w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_b_zero;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  step_mode_e         w_mode;
  logic [WIDTH-1:0]   w_step_acc, w_step_part;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix, w_fixed;

  assign w_mode = r_func_q[2] ? STEP_DIV : STEP_MUL;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .i_mode (w_mode),
    .i_acc  (r_acc_q),
    .i_part (r_part_q),
    .i_opnd (r_opnd_q),
    .o_acc  (w_step_acc),
    .o_part (w_step_part)
  );

  // Operand magnitudes and result sign, captured when a request is accepted
  always_comb begin
    w_a_signed = (func == c_func_mulh) || (func == c_func_mulhsu) ||
                 (func == c_func_div)  || (func == c_func_rem);
    w_b_signed = (func == c_func_mulh) || (func == c_func_div) ||
                 (func == c_func_rem);
    w_a_neg    = w_a_signed & opA[WIDTH-1];
    w_b_neg    = w_b_signed & opB[WIDTH-1];
    w_a_mag    = w_a_neg ? (~opA + WIDTH'(1)) : opA;
    w_b_mag    = w_b_neg ? (~opB + WIDTH'(1)) : opB;
    w_b_zero   = (opB == '0);
  end

  // Sign fix-up and func selection of the final value
  always_comb begin
    w_prod     = {r_acc_q, r_part_q};
    w_prod_fix = r_neg_q ? (~w_prod + (2*WIDTH)'(1)) : w_prod;
    w_quo_fix  = r_neg_q ? (~r_part_q + WIDTH'(1)) : r_part_q;
    w_rem_fix  = r_neg_q ? (~r_acc_q + WIDTH'(1)) : r_acc_q;
    case (r_func_q)
      c_func_mul:                              w_fixed = w_prod_fix[WIDTH-1:0];
      c_func_mulh, c_func_mulhsu, c_func_mulhu: w_fixed = w_prod_fix[2*WIDTH-1:WIDTH];
      c_func_div, c_func_divu:                 w_fixed = r_div0_q ? '1 : w_quo_fix;
      default:                                 w_fixed = r_div0_q ? r_opa_q : w_rem_fix;
    endcase
  end

  always_comb begin
    w_state_d  = r_state_q;
    w_cnt_d    = r_cnt_q;
    w_func_d   = r_func_q;
    w_acc_d    = r_acc_q;
    w_part_d   = r_part_q;
    w_opnd_d   = r_opnd_q;
    w_opa_d    = r_opa_q;
    w_neg_d    = r_neg_q;
    w_div0_d   = r_div0_q;
    w_result_d = r_result_q;
    case (r_state_q)
      ST_IDLE: begin
        if (start) begin
          w_func_d = func;
          w_acc_d  = '0;
          w_part_d = func[2] ? w_a_mag : w_b_mag;
          w_opnd_d = func[2] ? w_b_mag : w_a_mag;
          w_opa_d  = opA;
          w_neg_d  = (func == c_func_rem) ? w_a_neg : (w_a_neg ^ w_b_neg);
          w_div0_d = w_b_zero;
          w_cnt_d  = c_cnt_w'(WIDTH);
`ifdef MULDIV_EARLY_OUT_EN
          w_state_d = (func[2] && w_b_zero) ? ST_DONE : ST_CALC;
`else
          w_state_d = ST_CALC;
`endif
        end
      end
      ST_CALC: begin
        w_acc_d  = w_step_acc;
        w_part_d = w_step_part;
        w_cnt_d  = r_cnt_q - c_cnt_w'(1);
        if (w_cnt_d == '0) begin
          w_state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        w_result_d = w_fixed;
        w_state_d  = ST_IDLE;
      end
      default: begin
        w_state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q  <= ST_IDLE;
      r_cnt_q    <= '0;
      r_func_q   <= '0;
      r_acc_q    <= '0;
      r_part_q   <= '0;
      r_opnd_q   <= '0;
      r_opa_q    <= '0;
      r_neg_q    <= 1'b0;
      r_div0_q   <= 1'b0;
      r_result_q <= '0;
    end else begin
      r_state_q  <= w_state_d;
      r_cnt_q    <= w_cnt_d;
      r_func_q   <= w_func_d;
      r_acc_q    <= w_acc_d;
      r_part_q   <= w_part_d;
      r_opnd_q   <= w_opnd_d;
      r_opa_q    <= w_opa_d;
      r_neg_q    <= w_neg_d;
      r_div0_q   <= w_div0_d;
      r_result_q <= w_result_d;
    end
  end

  // The DONE cycle presents the fixed-up value while it is being registered
  assign busy   = (r_state_q != ST_IDLE);
  assign done   = (r_state_q == ST_DONE);
  assign result = done ? w_fixed : r_result_q;

endmodule

`default_nettype wire

// File: tb/tb_iterative_muldiv.sv
//------------------------------------------------------------------------------
// Module   : tb_iterative_muldiv
// Desc     : Directed self-checking bench for iterative_muldiv at WIDTH=32.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_iterative_muldiv;
  import muldiv_pkg::*;

`ifdef MULDIV_EARLY_OUT_EN
  localparam int c_div0_lat = 1;
`else
  localparam int c_div0_lat = 33;
`endif

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  func;
  logic [31:0] opA;
  logic [31:0] opB;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  iterative_muldiv #(
    .WIDTH (32)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .func   (func),
    .opA    (opA),
    .opB    (opB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Presents a request for one edge, then scrambles the inputs
  task automatic drive_start(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1;
    func  = f;
    opA   = a;
    opB   = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    func  = ~f;
    opA   = a ^ 32'hA5A5_5A5A;
    opB   = b ^ 32'h5A5A_A5A5;
  endtask

  // Cycle number (1 = first cycle after the start edge) at which done is seen
  task automatic wait_done(output int lat, output logic [31:0] res, output int busy_cnt);
    lat      = -1;
    res      = 'x;
    busy_cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) begin
        lat = c;
        res = result;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
    rst = 1'b0;
  endtask

  task automatic test_mul;
    int lat, bc;
    logic [31:0] res;
    drive_start(c_func_mul, 32'd7, 32'hFFFF_FFFD);
    wait_done(lat, res, bc);
    n_checks++;
    if (res !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result: got %h expected ffffffeb", res); end
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL mul_latency: got %0d expected 33", lat); end
    n_checks++;
    if (bc !== 33) begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected 33", bc); end
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL mul_done_pulse: got %b expected 0", done); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_busy_after: got %b expected 0", busy); end
    n_checks++;
    if (result !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_result_held: got %h expected ffffffeb", result); end
  endtask

  task automatic test_mul_high;
    logic [2:0]  fv [6];
    logic [31:0] av [6];
    logic [31:0] bv [6];
    logic [31:0] ev [6];
    int lat, bc;
    logic [31:0] res;
    fv = '{c_func_mulhu, c_func_mulh, c_func_mulhsu, c_func_mulh, c_func_mul, c_func_mul};
    av = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0001_2345, 32'd5};
    bv = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3, 32'h0000_0100, 32'd0};
    ev = '{32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0123_4500, 32'd0};
    for (int i = 0; i < 6; i++) begin
      drive_start(fv[i], av[i], bv[i]);
      wait_done(lat, res, bc);
      n_checks++;
      if (res !== ev[i]) begin
        n_fail++;
        $display("FAIL mul_vec%0d_result: got %h expected %h", i, res, ev[i]);
      end
      n_checks++;
      if (lat !== 33) begin
        n_fail++;
        $display("FAIL mul_vec%0d_latency: got %0d expected 33", i, lat);
      end
    end
  endtask

  task automatic test_div;
    logic [2:0]  fv [8];
    logic [31:0] av [8];
    logic [31:0] bv [8];
    logic [31:0] ev [8];
    int lat, bc;
    logic [31:0] res;
    fv = '{c_func_div, c_func_rem, c_func_rem, c_func_div,
           c_func_divu, c_func_remu, c_func_div, c_func_rem};
    av = '{32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
           32'd100, 32'd100, 32'd100, 32'd100};
    bv = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd2, 32'd2,
           32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFF9};
    ev = '{32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFD,
           32'd14, 32'd2, 32'hFFFF_FFF2, 32'd2};
    for (int i = 0; i < 8; i++) begin
      drive_start(fv[i], av[i], bv[i]);
      wait_done(lat, res, bc);
      n_checks++;
      if (res !== ev[i]) begin
        n_fail++;
        $display("FAIL div_vec%0d_result: got %h expected %h", i, res, ev[i]);
      end
      n_checks++;
      if (lat !== 33) begin
        n_fail++;
        $display("FAIL div_vec%0d_latency: got %0d expected 33", i, lat);
      end
    end
  endtask

  task automatic test_div_zero;
    logic [2:0]  fv [4];
    logic [31:0] av [4];
    logic [31:0] ev [4];
    int lat, bc;
    logic [31:0] res;
    fv = '{c_func_divu, c_func_remu, c_func_div, c_func_rem};
    av = '{32'd100, 32'd100, 32'hFFFF_FFFB, 32'hFFFF_FFFB};
    ev = '{32'hFFFF_FFFF, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
    for (int i = 0; i < 4; i++) begin
      drive_start(fv[i], av[i], 32'd0);
      wait_done(lat, res, bc);
      n_checks++;
      if (res !== ev[i]) begin
        n_fail++;
        $display("FAIL div0_vec%0d_result: got %h expected %h", i, res, ev[i]);
      end
      n_checks++;
      if (lat !== c_div0_lat) begin
        n_fail++;
        $display("FAIL div0_vec%0d_latency: got %0d expected %0d", i, lat, c_div0_lat);
      end
    end
  endtask

  task automatic test_ignore_start;
    int lat, extra;
    logic [31:0] res;
    @(negedge clk);
    start = 1'b1;
    func  = c_func_mul;
    opA   = 32'd3;
    opB   = 32'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = -1;
    res   = 'x;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c;
        res = result;
        break;
      end
      if (c == 5) begin
        start = 1'b1;
        func  = c_func_divu;
        opA   = 32'd1000;
        opB   = 32'd3;
      end else if (c == 6) begin
        start = 1'b0;
      end
    end
    n_checks++;
    if (res !== 32'd15) begin n_fail++; $display("FAIL ignore_result: got %h expected 0000000f", res); end
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 33", lat); end
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL ignore_no_second_op: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_mid_calc;
    int extra;
    drive_start(c_func_mul, 32'd9, 32'd9);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done: got %b expected 0", done); end
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL midrst_result: got %h expected 0", result); end
    rst   = 1'b0;
    extra = 0;
    repeat (50) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d done cycles expected 0", extra); end
  endtask

  task automatic test_back_to_back;
    int lat, bc;
    logic [31:0] res;
    drive_start(c_func_mulhu, 32'h0001_0000, 32'h0001_0000);
    wait_done(lat, res, bc);
    n_checks++;
    if (res !== 32'd1) begin n_fail++; $display("FAIL b2b_first_result: got %h expected 00000001", res); end
    // Request held from the DONE cycle: must be taken only once IDLE
    start = 1'b1;
    func  = c_func_divu;
    opA   = 32'd50;
    opB   = 32'd5;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap_busy: got %b expected 0", busy); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_gap_done: got %b expected 0", done); end
    @(posedge clk);
    #1;
    start = 1'b0;
    opA   = 32'd77;
    wait_done(lat, res, bc);
    n_checks++;
    if (res !== 32'd10) begin n_fail++; $display("FAIL b2b_second_result: got %h expected 0000000a", res); end
    n_checks++;
    if (lat !== 33) begin n_fail++; $display("FAIL b2b_second_latency: got %0d expected 33", lat); end
  endtask

  task automatic test_rst_priority;
    int extra, lat, bc;
    logic [31:0] res;
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    func  = c_func_mul;
    opA   = 32'd2;
    opB   = 32'd3;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rstprio_busy: got %b expected 0", busy); end
    n_checks++;
    if (result !== 32'h0) begin n_fail++; $display("FAIL rstprio_result: got %h expected 0", result); end
    rst   = 1'b0;
    start = 1'b0;
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) extra++;
    end
    n_checks++;
    if (extra !== 0) begin n_fail++; $display("FAIL rstprio_no_done: got %0d done cycles expected 0", extra); end
    drive_start(c_func_mul, 32'd6, 32'd7);
    wait_done(lat, res, bc);
    n_checks++;
    if (res !== 32'd42) begin n_fail++; $display("FAIL post_rst_result: got %h expected 0000002a", res); end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    func  = 3'b000;
    opA   = 32'h0;
    opB   = 32'h0;
    test_reset();
    test_mul();
    test_mul_high();
    test_div();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_calc();
    test_back_to_back();
    test_rst_priority();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
